// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the five-stage RV32I pipeline
module pipeline_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_mispredict,
  input  logic [31:0]      ex_target,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             if_id_flush,
  output logic             id_ex_load,
  output logic             id_ex_flush,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, REDIR_PEND} state_t;
  state_t state, state_nxt;
  logic [31:0] saved_target;
  logic capture, flush_inc;
  logic mem_stall, fetch_stall, lu_hazard;
  assign mem_stall   = dmem_req & ~dmem_resp;
  assign fetch_stall = ~imem_resp;
  assign lu_hazard   = ex_is_load & (ex_rd != 5'd0) &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  // Strobe generation and next-state; earlier hazards take priority over later ones
  always_comb begin
    pc_load        = 1'b0;
    if_id_load     = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_load     = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_load    = 1'b0;
    mem_wb_load    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = (state == REDIR_PEND) ? saved_target : ex_target;
    state_nxt      = state;
    capture        = 1'b0;
    flush_inc      = 1'b0;
    if (state == RUN) begin
      if (mem_stall) begin
        pc_load = 1'b0;
      end else if (ex_mispredict) begin
        if_id_load     = 1'b1;
        if_id_flush    = 1'b1;
        id_ex_load     = 1'b1;
        id_ex_flush    = 1'b1;
        ex_mem_load    = 1'b1;
        mem_wb_load    = 1'b1;
        flush_inc      = 1'b1;
        pc_load        = imem_resp;
        redirect_valid = imem_resp;
        capture        = ~imem_resp;
        state_nxt      = imem_resp ? RUN : REDIR_PEND;
      end else if (lu_hazard) begin
        id_ex_load  = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_load = 1'b1;
        mem_wb_load = 1'b1;
      end else begin
        pc_load     = ~fetch_stall;
        if_id_load  = 1'b1;
        if_id_flush = fetch_stall;
        id_ex_load  = 1'b1;
        ex_mem_load = 1'b1;
        mem_wb_load = 1'b1;
      end
    end else if (!mem_stall) begin
      pc_load        = imem_resp;
      redirect_valid = imem_resp;
      if_id_load     = 1'b1;
      if_id_flush    = 1'b1;
      id_ex_load     = 1'b1;
      ex_mem_load    = 1'b1;
      mem_wb_load    = 1'b1;
      state_nxt      = imem_resp ? RUN : REDIR_PEND;
    end
  end
  // State, deferred redirect target and performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      saved_target <= 32'd0;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (capture) saved_target <= ex_target;
      if (!pc_load) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central hazard and sequencing controller for the five-stage RV32I pipeline. It generates the load and flush strobes for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves memory stalls, load-use hazards, fetch misses and branch mispredicts, and owns PC redirection, including redirects deferred behind an outstanding I-cache access. It also keeps stall and flush performance counters.

Parameters:
CNT_W, 32, width of the stall_cnt and flush_cnt performance counters

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
imem_resp  in  1  I-cache returns the instruction for the current PC this cycle
dmem_req  in  1  MEM-stage instruction is a load or store
dmem_resp  in  1  D-cache completes the MEM-stage access this cycle
id_rs1  in  5  ID-stage source register 1
id_rs2  in  5  ID-stage source register 2
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  EX-stage destination register
ex_is_load  in  1  EX instruction is a load
ex_mispredict  in  1  EX-resolved branch/jump outcome differs from its prediction
ex_target  in  32  correct next PC from EX
pc_load  out  1  PC register enable
if_id_load  out  1  IF/ID load
if_id_flush  out  1  IF/ID loads a nop (valid only with if_id_load)
id_ex_load  out  1  ID/EX load
id_ex_flush  out  1  ID/EX loads a zeroed control word
ex_mem_load  out  1  EX/MEM load
mem_wb_load  out  1  MEM/WB load
redirect_valid  out  1  PC mux selects redirect_pc this cycle
redirect_pc  out  32  redirect target
stall_cnt  out  CNT_W  cycles with pc_load=0
flush_cnt  out  CNT_W  accepted mispredicts

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset: state=RUN, saved target=0, both counters=0. All outputs are combinational from state and inputs; none is registered.
- Derived signals:
  - mem_stall = dmem_req & ~dmem_resp
  - fetch_stall = ~imem_resp
  - lu_hazard = ex_is_load & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))
- Default for every output: 0.
- State RUN, first matching case wins:
  1. mem_stall: all loads 0. EX is frozen, so ex_mispredict persists and is handled once the stall clears.
  2. ex_mispredict: if_id load+flush, id_ex load+flush, ex_mem_load=1, mem_wb_load=1, flush_cnt+1.
     - If imem_resp: pc_load=1, redirect_valid=1, redirect_pc=ex_target.
     - Else: pc_load=0, capture ex_target into saved target, go to REDIR_PEND.
  3. lu_hazard: pc_load=0, if_id_load=0, id_ex load+flush, ex_mem_load=1, mem_wb_load=1.
  4. fetch_stall: pc_load=0, if_id load+flush, all other loads 1.
  5. Otherwise: all loads 1, no flushes.
- State REDIR_PEND (front end holds only bubbles; mispredict and load-use are not evaluated):
  - mem_stall: all loads 0, stay in REDIR_PEND.
  - imem_resp: pc_load=1, redirect_valid=1, redirect_pc=saved target, if_id load+flush (discards the wrong-path instruction), id_ex/ex_mem/mem_wb load 1, go to RUN.
  - Otherwise: pc_load=0, if_id load+flush, other loads 1.
- redirect_pc is ex_target in RUN and the saved target in REDIR_PEND, whatever redirect_valid is.
- stall_cnt increments every cycle pc_load=0, including mem_stall cycles, in both states.
- Counters wrap modulo 2^CNT_W.
- A flush strobe is never asserted without its matching load strobe.
- Reset asserted mid-REDIR_PEND returns asynchronously to RUN and discards the saved target.

Test Plan:
1. Idle flow: imem_resp=1, dmem_req=0, no hazards for 10 cycles -> all loads 1, no flushes, stall_cnt=0.
2. Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for one cycle -> pc_load=0, if_id_load=0, id_ex_load=1 with id_ex_flush=1; stall_cnt becomes 1.
3. D-cache miss: dmem_req=1, dmem_resp=0 for 4 cycles, then dmem_resp=1 -> all loads 0 for 4 cycles, then all 1; stall_cnt=4.
4. Immediate redirect: ex_mispredict=1, ex_target=0x60, imem_resp=1 -> redirect_valid=1, redirect_pc=0x60, if_id and id_ex flushed; flush_cnt=1.
5. Deferred redirect: ex_mispredict=1, ex_target=0x1000, imem_resp=0 for 3 cycles (ex_target changes to 0xDEAD after the first cycle), then imem_resp=1 -> REDIR_PEND entered; pc_load=0 for 3 cycles; then redirect_valid=1, redirect_pc=0x1000, if_id flushed; back to RUN.
6. Mispredict under D-miss, then reset: ex_mispredict=1 with mem_stall for 2 cycles -> no flush and flush_cnt unchanged until the stall clears, then exactly one flush. Drop rst_n while in REDIR_PEND -> state RUN and counters 0 immediately, without waiting for a clock edge.
